// File: rtl/uart_kw_pkg.sv
// Shared constants and helpers for the UART keyword matcher.
// Table helpers take a maximum-width table so that any legal NUM_KW/MAX_LEN
// configuration fits. Callers zero-extend their own narrower tables.
package uart_kw_pkg;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam int         IDX_W     = 4;
  localparam int         MAX_KW    = 15;
  localparam int         MAX_CHARS = 15;
  localparam int         TBL_W     = MAX_KW * MAX_CHARS * 8;
  localparam int         LENS_W    = MAX_KW * IDX_W;

  // Character j of keyword k, where each keyword occupies max_len byte slots.
  function automatic logic [7:0] kw_char(input logic [TBL_W-1:0] tbl,
                                         input int k, input int j,
                                         input int max_len);
    return tbl[(k * max_len + j) * 8 +: 8];
  endfunction

  // Length field of keyword k.
  function automatic logic [IDX_W-1:0] kw_len(input logic [LENS_W-1:0] lens,
                                              input int k);
    return lens[k * IDX_W +: IDX_W];
  endfunction

  // ASCII 'A'..'Z' mapped onto 'a'..'z', everything else unchanged.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
  endfunction

endpackage

// File: rtl/uart_kw_tracker.sv
// Single-keyword position tracker.
// pos is the number of keyword characters already matched. A byte that does
// not continue the keyword either restarts at position 1 (when it equals the
// first character) or drops back to 0. hit is combinational and is
// registered by the top. Handshake: a byte is consumed on every cycle with
// valid=1; clr wins over a same-cycle byte, which is then dropped.
module uart_kw_tracker
  import uart_kw_pkg::*;
#(
  parameter int                   MAX_LEN = 8,
  parameter logic [MAX_LEN*8-1:0] KW      = '0,
  parameter int                   LEN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data_byte,
  input  logic       clr,
  output logic       hit,
  output logic       active
);

  localparam logic [TBL_W-1:0] KW_EXT = TBL_W'(KW);
  localparam logic [7:0]       FIRST  = kw_char(KW_EXT, 0, 0, MAX_LEN);

  logic [IDX_W-1:0] pos;
  logic [7:0]       exp_char;
  logic             at_last;

  // Character expected next and whether it would complete the keyword.
  always_comb begin
    exp_char = kw_char(KW_EXT, 0, int'(pos), MAX_LEN);
    at_last  = ({1'b0, pos} + 5'd1) == 5'(LEN);
  end

  // A one-character keyword completes through this path as well, since its
  // expected character is always the first one.
  assign hit    = valid && !clr && (data_byte == exp_char) && at_last;
  assign active = (pos != '0);

  // Position update: advance, restart on the first character, or drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (valid) begin
      if (data_byte == exp_char) begin
        pos <= at_last ? '0 : pos + 1'b1;
      end else if (data_byte == FIRST) begin
        pos <= (LEN == 1) ? '0 : IDX_W'(1);
      end else begin
        pos <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_kw_matcher.sv
// Streaming multi-keyword matcher for the UART RX byte stream.
// One tracker per keyword; the top folds case (optional), runs the idle
// timeout, picks the lowest-index hit and registers match/match_idx/match_code.
// Optional feature macro: KW_CASE_FOLD_EN (uppercase input folded to
// lowercase before comparison; the keyword table must be lowercase).
module uart_kw_matcher
  import uart_kw_pkg::*;
#(
  parameter int                          NUM_KW      = 4,
  parameter int                          MAX_LEN     = 8,
  parameter logic [NUM_KW*MAX_LEN*8-1:0] KW_TABLE    = {24'h0, "teser", 24'h0, "zstih",
                                                        32'h0, "pots",  24'h0, "trats"},
  parameter logic [NUM_KW*4-1:0]         KW_LEN      = {4'd5, 4'd5, 4'd4, 4'd5},
  parameter int                          TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data_in,
  input  logic       clear,
  output logic       match,
  output logic [3:0] match_idx,
  output logic [7:0] match_code,
  output logic       busy
);

  localparam logic [LENS_W-1:0] LENS_EXT = LENS_W'(KW_LEN);
  localparam logic [31:0]       TO_LAST  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  logic [7:0]        cmp_byte;
  logic [NUM_KW-1:0] hit_vec;
  logic [NUM_KW-1:0] act_vec;
  logic              any_hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [31:0]       idle_cnt;
  logic              timeout_fire;
  logic              trk_clr;

`ifdef KW_CASE_FOLD_EN
  assign cmp_byte = to_lower(data_in);
`else
  assign cmp_byte = data_in;
`endif

  // Timeout fires on the idle cycle that brings the idle run to TIMEOUT_CYC.
  assign timeout_fire = (TIMEOUT_CYC != 0) && !valid && (idle_cnt >= TO_LAST);
  assign trk_clr      = clear | timeout_fire;
  assign busy         = |act_vec;

  for (genvar k = 0; k < NUM_KW; k++) begin : g_trk
    localparam logic [MAX_LEN*8-1:0] KW_K  = KW_TABLE[k*MAX_LEN*8 +: MAX_LEN*8];
    localparam int                   LEN_K = int'(kw_len(LENS_EXT, k));

    uart_kw_tracker #(
      .MAX_LEN (MAX_LEN),
      .KW      (KW_K),
      .LEN     (LEN_K)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .data_byte (cmp_byte),
      .clr       (trk_clr),
      .hit       (hit_vec[k]),
      .active    (act_vec[k])
    );
  end

  // Priority encoder: lowest keyword index wins when several complete at once.
  always_comb begin
    any_hit = |hit_vec;
    hit_idx = '0;
    for (int k = NUM_KW - 1; k >= 0; k--) begin
      if (hit_vec[k]) hit_idx = IDX_W'(k);
    end
  end

  // Idle counter: counts cycles without a byte, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (clear || valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Result registers: pulse on completion, index/code held until next hit or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match      <= 1'b0;
      match_idx  <= '0;
      match_code <= ASCII_0;
    end else if (clear) begin
      match      <= 1'b0;
      match_code <= ASCII_0;
    end else begin
      match <= any_hit;
      if (any_hit) begin
        match_idx  <= hit_idx;
        match_code <= ASCII_0 + 8'd1 + 8'(hit_idx);
      end
    end
  end

endmodule

// File: tb/tb_uart_kw_matcher.sv
// Bench for uart_kw_matcher with the default keyword table and a 16-cycle
// idle timeout. Directed table, hand-written corner sequences, then random
// traffic checked against a history-based reference model.
module tb_uart_kw_matcher;

  localparam int TO = 16;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         c;
    bit         e_match;
    logic [3:0] e_idx;
    logic [7:0] e_code;
    bit         e_busy;
  } vec_t;

  logic       clk, rst, valid, clear;
  logic [7:0] data_in;
  logic       match, busy;
  logic [3:0] match_idx;
  logic [7:0] match_code;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];

  uart_kw_matcher #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .data_in    (data_in),
    .clear      (clear),
    .match      (match),
    .match_idx  (match_idx),
    .match_code (match_code),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each keyword keeps the bytes seen since its last flush. A keyword hits
  // when its recent bytes end with the full keyword; busy means the recent
  // bytes end with a non-empty proper prefix of some keyword.
  string      kws[4] = '{"start", "stop", "hitsz", "reset"};
  logic [7:0] hist[4][8];
  int         hcnt[4];
  int         idle_run;
  bit         m_match, m_busy;
  logic [3:0] m_idx;
  logic [7:0] m_code;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef KW_CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
`endif
    return b;
  endfunction

  function automatic bit ends_with(input int k, input int l);
    if (hcnt[k] < l) return 0;
    for (int i = 0; i < l; i++)
      if (hist[k][8 - l + i] != kws[k][i]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) hcnt[k] = 0;
    idle_run = 0;
    m_match  = 0;
    m_idx    = 0;
    m_code   = 8'h30;
    m_busy   = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    bit any;
    logic [7:0] b;
    any = 0;
    m_match = 0;
    if (c) begin
      for (int k = 0; k < 4; k++) hcnt[k] = 0;
      idle_run = 0;
      m_code = 8'h30;
    end else if (v) begin
      idle_run = 0;
      b = fold(d);
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 7; j++) hist[k][j] = hist[k][j + 1];
        hist[k][7] = b;
        if (hcnt[k] < 8) hcnt[k]++;
        if (ends_with(k, kws[k].len())) begin
          hcnt[k] = 0;
          if (!any) begin
            any    = 1;
            m_idx  = 4'(k);
            m_code = 8'h31 + 8'(k);
          end
        end
      end
      m_match = any;
    end else begin
      idle_run++;
      if (idle_run >= TO)
        for (int k = 0; k < 4; k++) hcnt[k] = 0;
    end
    m_busy = 0;
    for (int k = 0; k < 4; k++)
      for (int l = 1; l < kws[k].len(); l++)
        if (ends_with(k, l)) m_busy = 1;
    exp_q.push_back({m_match, m_idx, m_code, m_busy});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input bit em, input logic [3:0] ei,
                       input logic [7:0] ec, input bit eb);
    n_vec++;
    if (match !== em || match_idx !== ei || match_code !== ec || busy !== eb) begin
      n_err++;
      $display("FAIL %s: got match=%0b idx=%0d code=%02h busy=%0b, expected match=%0b idx=%0d code=%02h busy=%0b",
               name, match, match_idx, match_code, busy, em, ei, ec, eb);
    end
  endtask

  // ---------------- driver ----------------
  // Every clock edge goes through apply so the model stays cycle-aligned.
  task automatic apply(input bit v, input logic [7:0] d, input bit c,
                       input bit chk, input string name);
    logic [13:0] e;
    @(negedge clk);
    valid   = v;
    data_in = d;
    clear   = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
    e = exp_q.pop_front();
    if (chk) check(name, e[13], e[12:9], e[8:1], e[0]);
  endtask

  task automatic send_str(input string s, input int gap, input string name);
    for (int i = 0; i < s.len(); i++) begin
      apply(1'b1, s[i], 1'b0, 1'b1, name);
      if (i < s.len() - 1)
        for (int g = 0; g < gap; g++) apply(1'b0, 8'h00, 1'b0, 1'b1, name);
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) apply(1'b0, 8'h00, 1'b0, 1'b1, name);
  endtask

  // ---------------- test ----------------
  vec_t  tbl[18];
  string alph = "startopihzre";
  logic [9:0] pend[$];

  initial begin
    // "start" back to back, then "ststop", then "sto" with clear on 'p'
    tbl[0]  = '{1, "s", 0, 0, 0, 8'h30, 1};
    tbl[1]  = '{1, "t", 0, 0, 0, 8'h30, 1};
    tbl[2]  = '{1, "a", 0, 0, 0, 8'h30, 1};
    tbl[3]  = '{1, "r", 0, 0, 0, 8'h30, 1};
    tbl[4]  = '{1, "t", 0, 1, 0, 8'h31, 0};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 8'h31, 0};
    tbl[6]  = '{1, "s", 0, 0, 0, 8'h31, 1};
    tbl[7]  = '{1, "t", 0, 0, 0, 8'h31, 1};
    tbl[8]  = '{1, "s", 0, 0, 0, 8'h31, 1};
    tbl[9]  = '{1, "t", 0, 0, 0, 8'h31, 1};
    tbl[10] = '{1, "o", 0, 0, 0, 8'h31, 1};
    tbl[11] = '{1, "p", 0, 1, 1, 8'h32, 0};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 8'h32, 0};
    tbl[13] = '{1, "s", 0, 0, 1, 8'h32, 1};
    tbl[14] = '{1, "t", 0, 0, 1, 8'h32, 1};
    tbl[15] = '{1, "o", 0, 0, 1, 8'h32, 1};
    tbl[16] = '{1, "p", 1, 0, 1, 8'h30, 0};
    tbl[17] = '{0, 8'h00, 0, 0, 1, 8'h30, 0};

    // reset
    rst = 1'b1; valid = 1'b0; clear = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_state", 0, 0, 8'h30, 0);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].c, 1'b0, "table");
      check($sformatf("table_%0d", i), tbl[i].e_match, tbl[i].e_idx, tbl[i].e_code, tbl[i].e_busy);
    end

    // "hitsz" with 3 idle cycles between bytes; partial position must hold
    send_str("hits", 3, "gap_seq");
    idle(3, "gap_seq");
    check("gap_busy_held", 0, 1, 8'h30, 1);
    apply(1'b1, "z", 1'b0, 1'b1, "gap_seq");
    check("gap_hitsz", 1, 2, 8'h33, 0);

    // timeout boundary: 15 idle cycles keep the partial match, 16 flush it
    send_str("hit", 0, "to15");
    idle(TO - 1, "to15");
    check("to15_busy", 0, 2, 8'h33, 1);
    send_str("sz", 0, "to15");
    check("to15_match", 1, 2, 8'h33, 0);
    send_str("hit", 0, "to16");
    idle(TO, "to16");
    check("to16_flushed", 0, 2, 8'h33, 0);
    send_str("sz", 0, "to16");
    check("to16_nomatch", 0, 2, 8'h33, 0);

    // async reset in the middle of "reset"
    send_str("res", 0, "rst_mid");
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    check("rst_mid_state", 0, 0, 8'h30, 0);
    send_str("et", 0, "rst_mid");
    check("rst_mid_nomatch", 0, 0, 8'h30, 0);

    // uppercase input
    send_str("RESET", 0, "upper");
`ifdef KW_CASE_FOLD_EN
    check("upper_fold", 1, 3, 8'h34, 0);
`else
    check("upper_exact", 0, 0, 8'h30, 0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if (pend.size() == 0) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) begin
          int k;
          logic [7:0] ch;
          k = $urandom_range(0, 3);
          for (int i = 0; i < kws[k].len(); i++) begin
            ch = kws[k][i];
            if ($urandom_range(0, 9) < 2) ch = ch - 8'h20;
            pend.push_back({1'b0, 1'b1, ch});
          end
        end else if (r < 18) begin
          int len;
          len = $urandom_range(10, 20);
          for (int i = 0; i < len; i++) pend.push_back(10'h000);
        end else if (r < 20) begin
          pend.push_back({1'b1, 1'($urandom_range(0, 1)), alph[$urandom_range(0, 11)]});
        end else if (r < 48) begin
          pend.push_back(10'h000);
        end else if (r < 90) begin
          pend.push_back({1'b0, 1'b1, alph[$urandom_range(0, 11)]});
        end else begin
          pend.push_back({1'b0, 1'b1, 8'($urandom_range(0, 255))});
        end
      end
      begin
        logic [9:0] it;
        it = pend.pop_front();
        apply(it[8], it[7:0], it[9], 1'b1, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
